// File: rtl/ctrl_pkg.sv
// rtl/ctrl_pkg.sv - opcode/funct constants, ALU codes, FSM states and pc_src encodings
package ctrl_pkg;
    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam logic [5:0] FN_ADD = 6'b100000;
    localparam logic [5:0] FN_SUB = 6'b100010;
    localparam logic [5:0] FN_AND = 6'b100100;
    localparam logic [5:0] FN_OR  = 6'b100101;
    localparam logic [5:0] FN_SLT = 6'b101010;

    localparam logic [2:0] ALU_AND  = 3'b000;
    localparam logic [2:0] ALU_OR   = 3'b001;
    localparam logic [2:0] ALU_ADD  = 3'b010;
    localparam logic [2:0] ALU_SUB  = 3'b110;
    localparam logic [2:0] ALU_SLT  = 3'b111;
    localparam logic [2:0] ALU_IDLE = 3'b000;

    localparam logic [1:0] PC_SRC_SEQ    = 2'b00;
    localparam logic [1:0] PC_SRC_BRANCH = 2'b01;
    localparam logic [1:0] PC_SRC_JUMP   = 2'b10;

    typedef enum logic [3:0] {
        S_FETCH, S_DECODE, S_EXEC_R, S_EXEC_I, S_MEM_ADDR, S_MEM_RD,
        S_MEM_WR, S_WB_ALU, S_WB_MEM, S_BRANCH, S_JUMP, S_ILLEGAL
    } state_e;

    typedef enum logic [1:0] {CLS_RTYPE, CLS_ADD, CLS_SUB, CLS_NONE} op_class_e;

    function automatic op_class_e op_class(input logic [5:0] opcode);
        case (opcode)
            OP_RTYPE:              return CLS_RTYPE;
            OP_ADDI, OP_LW, OP_SW: return CLS_ADD;
            OP_BEQ:                return CLS_SUB;
            default:               return CLS_NONE;
        endcase
    endfunction
endpackage

// File: rtl/multicycle_ctrl_alu_decoder.sv
// rtl/multicycle_ctrl_alu_decoder.sv - maps (opcode class, funct) to the 3-bit ALU control code
module alu_decoder
    import ctrl_pkg::*;
(
    input  op_class_e   op_class_i,
    input  logic [5:0]  funct_i,
    output logic [2:0]  alu_ctrl_o
);
    always_comb begin
        alu_ctrl_o = ALU_IDLE;
        case (op_class_i)
            CLS_RTYPE: begin
                case (funct_i)
                    FN_ADD:  alu_ctrl_o = ALU_ADD;
                    FN_SUB:  alu_ctrl_o = ALU_SUB;
                    FN_AND:  alu_ctrl_o = ALU_AND;
                    FN_OR:   alu_ctrl_o = ALU_OR;
                    FN_SLT:  alu_ctrl_o = ALU_SLT;
                    default: alu_ctrl_o = ALU_ADD;
                endcase
            end
            CLS_ADD: alu_ctrl_o = ALU_ADD;
            CLS_SUB: alu_ctrl_o = ALU_SUB;
            default: alu_ctrl_o = ALU_IDLE;
        endcase
    end
endmodule

// File: rtl/multicycle_ctrl.sv
// rtl/multicycle_ctrl.sv - multicycle MIPS-subset control FSM with mem_ready handshake
// Optional retired-instruction counter enabled by CTRL_PERF_CNT_EN.
module multicycle_ctrl
    import ctrl_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] instr_in,
    input  logic        zero,
    input  logic        mem_ready,
    output logic        pc_en,
    output logic [1:0]  pc_src,
    output logic        reg_write_en,
    output logic        reg_dst,
    output logic        alu_src,
    output logic [2:0]  alu_ctrl,
    output logic        mem_write_en,
    output logic        mem_to_reg,
    output logic        illegal_instr,
    output logic [31:0] instret
);
    state_e     state_q, state_d;
    logic [5:0] opcode_q, funct_q;
    logic [2:0] dec_alu_ctrl;
    logic       mux_active;
    logic       unused_instr_bits;

    assign unused_instr_bits = ^instr_in[25:6];

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_FETCH:  state_d = S_DECODE;
            S_DECODE: begin
                case (opcode_q)
                    OP_RTYPE:     state_d = S_EXEC_R;
                    OP_LW, OP_SW: state_d = S_MEM_ADDR;
                    OP_BEQ:       state_d = S_BRANCH;
                    OP_ADDI:      state_d = S_EXEC_I;
                    OP_J:         state_d = S_JUMP;
                    default:      state_d = S_ILLEGAL;
                endcase
            end
            S_EXEC_R, S_EXEC_I: state_d = S_WB_ALU;
            S_MEM_ADDR: state_d = (opcode_q == OP_LW) ? S_MEM_RD : S_MEM_WR;
            S_MEM_RD:   if (mem_ready) state_d = S_WB_MEM;
            S_MEM_WR:   if (mem_ready) state_d = S_FETCH;
            default:    state_d = S_FETCH;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_FETCH;
            opcode_q <= '0;
            funct_q  <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == S_FETCH) begin
                opcode_q <= instr_in[31:26];
                funct_q  <= instr_in[5:0];
            end
        end
    end

    alu_decoder u_alu_decoder (
        .op_class_i (op_class(opcode_q)),
        .funct_i    (funct_q),
        .alu_ctrl_o (dec_alu_ctrl)
    );

    // Mux selects stay stable from the execute/address cycle to the retiring cycle.
    always_comb begin
        mux_active = 1'b0;
        case (state_q)
            S_EXEC_R, S_EXEC_I, S_MEM_ADDR, S_MEM_RD, S_MEM_WR,
            S_WB_ALU, S_WB_MEM, S_BRANCH: mux_active = 1'b1;
            default: mux_active = 1'b0;
        endcase
    end

    // Reset masks every output so nothing fires in the cycle rst is sampled.
    always_comb begin
        pc_en         = 1'b0;
        pc_src        = PC_SRC_SEQ;
        reg_write_en  = 1'b0;
        reg_dst       = 1'b0;
        alu_src       = 1'b0;
        alu_ctrl      = ALU_IDLE;
        mem_write_en  = 1'b0;
        mem_to_reg    = 1'b0;
        illegal_instr = 1'b0;
        if (!rst) begin
            if (mux_active) begin
                alu_ctrl   = dec_alu_ctrl;
                reg_dst    = (opcode_q == OP_RTYPE);
                alu_src    = (opcode_q == OP_ADDI) || (opcode_q == OP_LW) || (opcode_q == OP_SW);
                mem_to_reg = (opcode_q == OP_LW);
            end
            case (state_q)
                S_WB_ALU, S_WB_MEM: begin
                    reg_write_en = 1'b1;
                    pc_en        = 1'b1;
                end
                S_MEM_WR: begin
                    mem_write_en = mem_ready;
                    pc_en        = mem_ready;
                end
                S_BRANCH: begin
                    pc_en  = 1'b1;
                    pc_src = zero ? PC_SRC_BRANCH : PC_SRC_SEQ;
                end
                S_JUMP: begin
                    pc_en  = 1'b1;
                    pc_src = PC_SRC_JUMP;
                end
                S_ILLEGAL: begin
                    pc_en         = 1'b1;
                    illegal_instr = 1'b1;
                end
                default: ;
            endcase
        end
    end

`ifdef CTRL_PERF_CNT_EN
    logic [31:0] instret_q;

    always_ff @(posedge clk) begin
        if (rst)
            instret_q <= '0;
        else if (pc_en)
            instret_q <= instret_q + 32'd1;
    end

    assign instret = instret_q;
`else
    assign instret = '0;
`endif
endmodule

// File: tb/tb_multicycle_ctrl.sv
// tb/tb_multicycle_ctrl.sv - directed vector bench for multicycle_ctrl
module tb_multicycle_ctrl;
    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] instr_in;
    logic        zero;
    logic        mem_ready;
    logic        pc_en;
    logic [1:0]  pc_src;
    logic        reg_write_en;
    logic        reg_dst;
    logic        alu_src;
    logic [2:0]  alu_ctrl;
    logic        mem_write_en;
    logic        mem_to_reg;
    logic        illegal_instr;
    logic [31:0] instret;

    int n_checks = 0;
    int n_fail   = 0;
    int n_retired = 0;

    multicycle_ctrl dut (
        .clk           (clk),
        .rst           (rst),
        .instr_in      (instr_in),
        .zero          (zero),
        .mem_ready     (mem_ready),
        .pc_en         (pc_en),
        .pc_src        (pc_src),
        .reg_write_en  (reg_write_en),
        .reg_dst       (reg_dst),
        .alu_src       (alu_src),
        .alu_ctrl      (alu_ctrl),
        .mem_write_en  (mem_write_en),
        .mem_to_reg    (mem_to_reg),
        .illegal_instr (illegal_instr),
        .instret       (instret)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic [31:0] instr;
        logic        zero;
        logic        rdy;
        int          cycles;
        logic        chk_alu;
        logic [1:0]  pc_src;
        logic        rw;
        logic        rd;
        logic        as;
        logic [2:0]  alu;
        logic        mw;
        logic        m2r;
        logic        ill;
    } vec_t;

    vec_t vecs[14];

    task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", nm, got, exp);
        end
    endtask

    function automatic logic [11:0] all_outs();
        return {pc_en, pc_src, reg_write_en, reg_dst, alu_src, alu_ctrl,
                mem_write_en, mem_to_reg, illegal_instr};
    endfunction

    function automatic logic [31:0] exp_instret();
`ifdef CTRL_PERF_CNT_EN
        return n_retired;
`else
        return 32'd0;
`endif
    endfunction

    // Entered at a negedge with the FSM in FETCH; leaves at a negedge back in FETCH.
    task automatic run_vec(input vec_t v);
        int          cyc;
        logic        done;
        logic        early_bad;
        logic [10:0] got;
        logic [10:0] exp;
        instr_in  = v.instr;
        zero      = v.zero;
        mem_ready = v.rdy;
        cyc = 0; done = 1'b0; early_bad = 1'b0; got = '0;
        while (!done && cyc < 12) begin
            cyc++;
            #1;
            if (pc_en) begin
                done = 1'b1;
                got  = {pc_src, reg_write_en, reg_dst, alu_src, alu_ctrl,
                        mem_write_en, mem_to_reg, illegal_instr};
            end else if (reg_write_en || mem_write_en || illegal_instr || pc_src != 2'b00) begin
                early_bad = 1'b1;
            end
            @(posedge clk);
            @(negedge clk);
        end
        if (done) n_retired++;
        exp = {v.pc_src, v.rw, v.rd, v.as, v.alu, v.mw, v.m2r, v.ill};
        if (!v.chk_alu) begin
            got[5:3] = 3'b000;
            exp[5:3] = 3'b000;
        end
        check($sformatf("%s_cycles", v.name), cyc, v.cycles);
        check($sformatf("%s_final_outs", v.name), {21'd0, got}, {21'd0, exp});
        check($sformatf("%s_early_quiet", v.name), {31'd0, early_bad}, 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int   cyc;
        logic done;
        logic rw_bad;
        int   mw_count;
        int   mw_cyc;

        //        name       instr         z  rdy cyc chk pc_src rw rd as alu    mw m2r ill
        vecs[0]  = '{"add",   32'h00221820, 0, 1, 4, 1, 2'b00, 1, 1, 0, 3'b010, 0, 0, 0};
        vecs[1]  = '{"sub",   32'h00221822, 0, 1, 4, 1, 2'b00, 1, 1, 0, 3'b110, 0, 0, 0};
        vecs[2]  = '{"and",   32'h00221824, 0, 1, 4, 1, 2'b00, 1, 1, 0, 3'b000, 0, 0, 0};
        vecs[3]  = '{"or",    32'h00221825, 0, 1, 4, 1, 2'b00, 1, 1, 0, 3'b001, 0, 0, 0};
        vecs[4]  = '{"slt",   32'h0022182A, 0, 1, 4, 1, 2'b00, 1, 1, 0, 3'b111, 0, 0, 0};
        vecs[5]  = '{"rfunk", 32'h0000003F, 0, 1, 4, 1, 2'b00, 1, 1, 0, 3'b010, 0, 0, 0};
        vecs[6]  = '{"addi",  32'h20220005, 0, 1, 4, 1, 2'b00, 1, 0, 1, 3'b010, 0, 0, 0};
        vecs[7]  = '{"lw",    32'h8C220004, 0, 1, 5, 1, 2'b00, 1, 0, 1, 3'b010, 0, 1, 0};
        vecs[8]  = '{"sw",    32'hAC220004, 0, 1, 4, 1, 2'b00, 0, 0, 1, 3'b010, 1, 0, 0};
        vecs[9]  = '{"beq_t", 32'h10220003, 1, 1, 3, 1, 2'b01, 0, 0, 0, 3'b110, 0, 0, 0};
        vecs[10] = '{"beq_n", 32'h10220003, 0, 1, 3, 1, 2'b00, 0, 0, 0, 3'b110, 0, 0, 0};
        vecs[11] = '{"j",     32'h08000010, 1, 1, 3, 0, 2'b10, 0, 0, 0, 3'b000, 0, 0, 0};
        vecs[12] = '{"illeg", 32'hFC000000, 1, 1, 3, 0, 2'b00, 0, 0, 0, 3'b000, 0, 0, 1};
        vecs[13] = '{"add_nr",32'h00221820, 1, 0, 4, 1, 2'b00, 1, 1, 0, 3'b010, 0, 0, 0};

        rst = 1'b1; instr_in = 32'hFFFFFFFF; zero = 1'b1; mem_ready = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_outs", {20'd0, all_outs()}, 32'd0);
        check("reset_instret", instret, 32'd0);
        rst = 1'b0;
        #1;
        check("fetch_outs", {20'd0, all_outs()}, 32'd0);
        @(negedge clk);
        // One negedge into FETCH: the FSM took DECODE with IR=FFFF... -> restart cleanly.
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 14; i++) run_vec(vecs[i]);
        check("instret_after_table", instret, exp_instret());

        instr_in = 32'h8C220004; zero = 1'b0;
        cyc = 0; done = 1'b0; rw_bad = 1'b0;
        while (!done && cyc < 12) begin
            cyc++;
            mem_ready = !(cyc == 4 || cyc == 5);
            #1;
            if (pc_en) begin
                done = 1'b1;
                check("lw_wait_rw_last", {31'd0, reg_write_en}, 32'd1);
                check("lw_wait_m2r_last", {31'd0, mem_to_reg}, 32'd1);
            end else if (reg_write_en) rw_bad = 1'b1;
            @(posedge clk);
            @(negedge clk);
        end
        if (done) n_retired++;
        check("lw_wait_cycles", cyc, 7);
        check("lw_wait_rw_early", {31'd0, rw_bad}, 32'd0);

        instr_in = 32'hAC220004;
        cyc = 0; done = 1'b0; rw_bad = 1'b0; mw_count = 0; mw_cyc = 0;
        while (!done && cyc < 12) begin
            cyc++;
            mem_ready = (cyc != 4);
            #1;
            if (mem_write_en) begin mw_count++; mw_cyc = cyc; end
            if (reg_write_en) rw_bad = 1'b1;
            if (pc_en) done = 1'b1;
            @(posedge clk);
            @(negedge clk);
        end
        if (done) n_retired++;
        check("sw_wait_cycles", cyc, 5);
        check("sw_wait_mw_count", mw_count, 1);
        check("sw_wait_mw_cycle", mw_cyc, 5);
        check("sw_wait_no_rw", {31'd0, rw_bad}, 32'd0);
        check("instret_after_waits", instret, exp_instret());

        instr_in = 32'h8C220004; mem_ready = 1'b0;
        repeat (4) begin
            @(posedge clk);
        end
        @(negedge clk);
        instr_in = 32'h00221820;
        rst = 1'b1;
        #1;
        check("rst_in_wait_outs", {20'd0, all_outs()}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        n_retired = 0;
        #1;
        check("after_rst_outs", {20'd0, all_outs()}, 32'd0);
        check("after_rst_instret", instret, 32'd0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;

        run_vec(vecs[0]);
        run_vec(vecs[9]);
        run_vec(vecs[12]);
        run_vec(vecs[8]);
        run_vec(vecs[7]);
        check("instret_five", instret, exp_instret());

`ifdef CTRL_PERF_CNT_EN
        force dut.instret_q = 32'hFFFFFFFF;
        #1;
        release dut.instret_q;
        run_vec(vecs[11]);
        check("instret_wrap", instret, 32'd0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
